// File: rtl/arbitro_rr_4_a_1_pkg.sv
// Shared types and sizes for the 4-to-1 round-robin arbiter slice.
package arbitro_rr_4_a_1_pkg;

    localparam int SEL_W = 2;
    localparam int N_REQ = 4;
    localparam int CNT_W = 4;

    typedef enum logic {
        REPOSO  = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

endpackage

// File: rtl/prioridad_rr_4.sv
// Rotating-priority picker: first active request after base, wrapping back to base itself.
module prioridad_rr_4
    import arbitro_rr_4_a_1_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    output logic [SEL_W-1:0] winner,
    output logic             any_req
);

    logic [SEL_W-1:0] idx;

    // Scan from farthest to nearest so the last hit is the highest-priority one.
    always_comb begin
        winner  = base;
        any_req = |req;
        idx     = '0;
        for (int unsigned d = N_REQ; d >= 1; d--) begin
            idx = base + SEL_W'(d);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_4_a_1.sv
// Round-robin 4:1 arbiter with bounded bursts, feeding one registered valid/ready output.
module arbitro_rr_4_a_1
    import arbitro_rr_4_a_1_pkg::*;
#(
    parameter int n          = 4,
    parameter int MAX_RAFAGA = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    input  logic [n-1:0]     i_Datos_0,
    input  logic [n-1:0]     i_Datos_1,
    input  logic [n-1:0]     i_Datos_2,
    input  logic [n-1:0]     i_Datos_3,
    input  logic             i_ready,
    output logic [N_REQ-1:0] o_ack,
    output logic [n-1:0]     o_Datos,
    output logic             o_valid,
    output logic [SEL_W-1:0] o_sel
);

    estado_t          state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             carga;
    logic             cont;
    logic             any_req;
    logic [SEL_W-1:0] rr_winner;
    logic [SEL_W-1:0] winner;
    logic [n-1:0]     dato_win;

    prioridad_rr_4 u_prioridad (
        .req     (i_req),
        .base    (o_sel),
        .winner  (rr_winner),
        .any_req (any_req)
    );

    // The current owner keeps the grant while it still requests and has burst budget.
    assign cont   = (state == ENTREGA) && i_req[o_sel] && (cnt < CNT_W'(MAX_RAFAGA));
    assign winner = cont ? o_sel : rr_winner;

    always_comb begin
        unique case (winner)
            2'd0:    dato_win = i_Datos_0;
            2'd1:    dato_win = i_Datos_1;
            2'd2:    dato_win = i_Datos_2;
            default: dato_win = i_Datos_3;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= REPOSO;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (carga) begin
            state_next = any_req ? ENTREGA : REPOSO;
        end
    end

    // Acks are suppressed during reset so no requester believes its word was taken.
    always_comb begin
        o_valid = (state == ENTREGA);
        carga   = (state == REPOSO) || (o_valid && i_ready);
        o_ack   = '0;
        if (carga && any_req && i_rst_n) begin
            o_ack[winner] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_Datos <= '0;
            o_sel   <= '1;
            cnt     <= '0;
        end else if (carga && any_req) begin
            o_Datos <= dato_win;
            o_sel   <= winner;
            cnt     <= cont ? cnt + CNT_W'(1) : CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_arbitro_rr_4_a_1.sv
// Bench for arbitro_rr_4_a_1: two instances (burst 4 and burst 1) against a behavioural model.
module tb_arbitro_rr_4_a_1;

    localparam int N = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   req   = '0;
    logic         ready = 1'b0;
    logic [N-1:0] dat [4];

    logic [3:0]   ack   [2];
    logic [N-1:0] datos [2];
    logic         valid [2];
    logic [1:0]   sel   [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arbitro_rr_4_a_1 #(.n(N), .MAX_RAFAGA(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_Datos_0(dat[0]), .i_Datos_1(dat[1]), .i_Datos_2(dat[2]), .i_Datos_3(dat[3]),
        .i_ready(ready), .o_ack(ack[0]), .o_Datos(datos[0]), .o_valid(valid[0]), .o_sel(sel[0])
    );

    arbitro_rr_4_a_1 #(.n(N), .MAX_RAFAGA(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
        .i_Datos_0(dat[0]), .i_Datos_1(dat[1]), .i_Datos_2(dat[2]), .i_Datos_3(dat[3]),
        .i_ready(ready), .o_ack(ack[1]), .o_Datos(datos[1]), .o_valid(valid[1]), .o_sel(sel[1])
    );

    // Behavioural model, one slot per instance: owner, burst length, held word, valid.
    int mv [2];
    int ms [2];
    int mc [2];
    int md [2];
    int mmax [2] = '{4, 1};

    function automatic int rotate(int base, logic [3:0] r);
        for (int d = 1; d <= 4; d++) begin
            if (r[(base + d) % 4]) return (base + d) % 4;
        end
        return -1;
    endfunction

    function automatic bit keeps(int i, logic [3:0] r);
        return (mv[i] != 0) && r[ms[i]] && (mc[i] < mmax[i]);
    endfunction

    function automatic int pick(int i, logic [3:0] r);
        if (keeps(i, r)) return ms[i];
        return rotate(ms[i], r);
    endfunction

    function automatic logic [3:0] exp_ack(int i);
        int w;
        if (!rst_n) return 4'b0000;
        if (mv[i] != 0 && !ready) return 4'b0000;
        w = pick(i, req);
        if (w < 0) return 4'b0000;
        return 4'b0001 << w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  w;
        bit  c;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mv[i] = 0; ms[i] = 3; mc[i] = 0; md[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!(mv[i] != 0 && !ready)) begin
                    c = keeps(i, req);
                    w = pick(i, req);
                    if (w < 0) begin
                        mv[i] = 0;
                    end else begin
                        mc[i] = c ? mc[i] + 1 : 1;
                        ms[i] = w;
                        md[i] = int'(dat[w]);
                        mv[i] = 1;
                    end
                end
            end
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m%0d.o_valid", i), 32'(valid[i]), 32'(mv[i]));
            chk($sformatf("m%0d.o_sel", i),   32'(sel[i]),   32'(ms[i]));
            chk($sformatf("m%0d.o_Datos", i), 32'(datos[i]), 32'(md[i]));
            chk($sformatf("m%0d.o_ack", i),   32'(ack[i]),   32'(exp_ack(i)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    int seq3 [6] = '{0, 1, 2, 3, 0, 1};
    int seq4 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

    initial begin
        for (int k = 0; k < 4; k++) dat[k] = '0;

        // 1: asynchronous reset with no edge, requests present
        req   = 4'b1111;
        ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("t1_valid", 32'(valid[0]), 0);
        chk("t1_sel",   32'(sel[0]),   3);
        chk("t1_datos", 32'(datos[0]), 0);
        chk("t1_ack",   32'(ack[0]),   0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // 2: single requester 2
        req = 4'b0100; dat[2] = 4'hA; ready = 1'b1;
        #1 chk("t2_ack", 32'(ack[0]), 32'b0100);
        cyc();
        #1;
        chk("t2_valid", 32'(valid[0]), 1);
        chk("t2_datos", 32'(datos[0]), 32'hA);
        chk("t2_sel",   32'(sel[0]),   2);
        req = 4'b0000;
        cyc();

        // 3: plain round robin on the burst-1 instance
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 4; k++) dat[k] = N'(k + 1);
        ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            cyc();
            #1;
            chk($sformatf("t3_sel%0d", j), 32'(sel[1]), 32'(seq3[j]));
            chk($sformatf("t3_valid%0d", j), 32'(valid[1]), 1);
        end

        // 4: bursts of four between two requesters, then a sole requester
        do_reset();
        req = 4'b0011;
        for (int j = 0; j < 9; j++) begin
            cyc();
            #1 chk($sformatf("t4_sel%0d", j), 32'(sel[0]), 32'(seq4[j]));
        end
        req = 4'b0001;
        for (int j = 0; j < 6; j++) begin
            cyc();
            #1;
            chk($sformatf("t4_solo_sel%0d", j), 32'(sel[0]), 0);
            chk($sformatf("t4_solo_valid%0d", j), 32'(valid[0]), 1);
        end

        // 5: backpressure while requests toggle
        do_reset();
        req = 4'b0010; dat[1] = 4'h5; ready = 1'b1;
        cyc();
        #1 chk("t5_sel0", 32'(sel[0]), 1);
        ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            req = 4'($urandom);
            for (int k = 0; k < 4; k++) dat[k] = N'($urandom);
            #1 chk($sformatf("t5_ack%0d", j), 32'(ack[0]), 0);
            cyc();
            #1;
            chk($sformatf("t5_sel%0d", j),   32'(sel[0]),   1);
            chk($sformatf("t5_datos%0d", j), 32'(datos[0]), 32'h5);
        end
        req = 4'b1000; dat[3] = 4'hC; ready = 1'b1;
        #1 chk("t5_ack_release", 32'(ack[0]), 32'b1000);
        cyc();
        #1;
        chk("t5_sel_after",   32'(sel[0]),   3);
        chk("t5_datos_after", 32'(datos[0]), 32'hC);

        // 6: reset in the middle of a requester-1 burst
        do_reset();
        req = 4'b0010; dat[1] = 4'h7; ready = 1'b1;
        cyc();
        cyc();
        #1 chk("t6_sel_burst", 32'(sel[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(valid[0]), 0);
        chk("t6_sel",   32'(sel[0]),   3);
        chk("t6_datos", 32'(datos[0]), 0);
        chk("t6_ack",   32'(ack[0]),   0);
        cyc();
        rst_n = 1'b1;
        req = 4'b1010; dat[3] = 4'h9;
        #1 chk("t6_ack_first", 32'(ack[0]), 32'b0010);
        cyc();
        #1;
        chk("t6_sel_first",   32'(sel[0]),   1);
        chk("t6_valid_first", 32'(valid[0]), 1);

        // Randomized traffic, backpressure and occasional reset pulses
        for (int j = 0; j < 400; j++) begin
            cyc();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
            req   = 4'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) dat[k] = N'($urandom);
        end

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
